// File: rtl/up_down_counter_param_if.sv
// Control and status bundle for up_down_counter_param.
// The master drives the count controls; the slave (the counter) returns count and status.
interface up_down_counter_param_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             up_down;
  logic             mode_wrap;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] lo_lim;
  logic [WIDTH-1:0] hi_lim;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_lo;
  logic             at_hi;
  logic             sat_hit;
  logic             wrap_pulse;
  logic             lim_err;

  modport master (
    output en, up_down, mode_wrap, step, lo_lim, hi_lim, load, load_val,
    input  count, at_lo, at_hi, sat_hit, wrap_pulse, lim_err
  );

  modport slave (
    input  en, up_down, mode_wrap, step, lo_lim, hi_lim, load, load_val,
    output count, at_lo, at_hi, sat_hit, wrap_pulse, lim_err
  );
endinterface

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with programmable limits and step, synchronous load,
// and saturate or wrap behaviour at the limits, plus registered limit-event pulses.
module up_down_counter_param #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  up_down_counter_param_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             sat_q;
  logic             wrap_q;
  logic             err_q;

  logic             window_ok;
  logic             step_active;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   diff_dn;
  logic             over_hi;
  logic             under_lo;
  logic             limit_hit;
  logic [WIDTH-1:0] step_count;

  // Widen by one bit so the up sum and down difference never overflow.
  assign window_ok   = bus.lo_lim <= bus.hi_lim;
  assign step_active = bus.en && (bus.step != '0) && window_ok;
  assign sum_up      = {1'b0, count_q} + {1'b0, bus.step};
  assign diff_dn     = {1'b0, count_q} - {1'b0, bus.step};
  assign over_hi     = sum_up > {1'b0, bus.hi_lim};
  assign under_lo    = (bus.step > count_q) || (diff_dn[WIDTH-1:0] < bus.lo_lim);
  assign limit_hit   = bus.up_down ? over_hi : under_lo;

  // Landing point for an enabled step: the sum/difference, or the limit on a violation.
  always_comb begin
    step_count = count_q;
    if (bus.up_down) begin
      if (!over_hi)            step_count = sum_up[WIDTH-1:0];
      else if (bus.mode_wrap)  step_count = bus.lo_lim;
      else                     step_count = bus.hi_lim;
    end else begin
      if (!under_lo)           step_count = diff_dn[WIDTH-1:0];
      else if (bus.mode_wrap)  step_count = bus.hi_lim;
      else                     step_count = bus.lo_lim;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; the reset branch is synchronous, so rst alone never clears state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      sat_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= !window_ok;
      sat_q  <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.load) begin
        count_q <= bus.load_val;
      end else if (step_active) begin
        count_q <= step_count;
        sat_q   <= limit_hit && !bus.mode_wrap;
        wrap_q  <= limit_hit &&  bus.mode_wrap;
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.sat_hit    = sat_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.lim_err    = err_q;
  assign bus.at_lo      = count_q == bus.lo_lim;
  assign bus.at_hi      = count_q == bus.hi_lim;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Self-checking bench for up_down_counter_param: directed limit scenarios plus
// randomized traffic compared against an integer-arithmetic reference model.
module tb_up_down_counter_param;
  localparam int         W       = 8;
  localparam logic [W-1:0] RST_V = 8'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model state (plain integers, following the counting rules directly).
  int m_count;
  bit m_sat, m_wrap, m_err;

  up_down_counter_param_if #(.WIDTH(W)) bus ();

  up_down_counter_param #(.WIDTH(W), .RST_VAL(RST_V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int c, s, lo, hi;
    bit hit;
    c  = m_count;
    s  = int'(bus.step);
    lo = int'(bus.lo_lim);
    hi = int'(bus.hi_lim);
    if (rst) begin
      m_count = int'(RST_V); m_sat = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_err = lo > hi; m_sat = 0; m_wrap = 0;
      if (bus.load) m_count = int'(bus.load_val);
      else if (bus.en && s != 0 && lo <= hi) begin
        hit = bus.up_down ? (c + s > hi) : (c - s < lo);
        if (!hit) m_count = bus.up_down ? c + s : c - s;
        else begin
          if (bus.mode_wrap) begin m_count = bus.up_down ? lo : hi; m_wrap = 1; end
          else               begin m_count = bus.up_down ? hi : lo; m_sat  = 1; end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] observe();
    return {bus.count, bus.at_lo, bus.at_hi, bus.sat_hit, bus.wrap_pulse, bus.lim_err};
  endfunction

  task automatic set_ctrl(input bit en, input bit up, input bit wrap, input int step,
                          input int lo, input int hi);
    bus.en = en; bus.up_down = up; bus.mode_wrap = wrap;
    bus.step = W'(step); bus.lo_lim = W'(lo); bus.hi_lim = W'(hi);
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    set_ctrl(0, 1, 0, 1, 0, 255);
    bus.load = 0; bus.load_val = '0;
    rst = 1; tick(); rst = 0;
    exp = {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL reset: got %h want %h", observe(), exp);
    end
  endtask

  task automatic test_sat_up_full();
    logic [12:0] exp;
    int v;
    set_ctrl(1, 1, 0, 1, 0, 255);
    for (int i = 1; i <= 260; i++) begin
      tick();
      v = (i > 255) ? 255 : i;
      exp = {8'(v), 1'b0, 1'(i >= 255), 1'(i >= 256), 1'b0, 1'b0};
      total++;
      if (observe() !== exp) begin
        bad++; $display("FAIL sat_up cycle %0d: got %h want %h", i, observe(), exp);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [12:0] exp;
    int seq [5] = '{10, 13, 16, 19, 10};
    set_ctrl(1, 1, 1, 3, 10, 20);
    bus.load = 1; bus.load_val = 8'd18; tick(); bus.load = 0;
    exp = {8'd18, 5'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL wrap_load: got %h want %h", observe(), exp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {8'(seq[i]), 1'(seq[i] == 10), 1'b0, 1'b0, 1'(seq[i] == 10), 1'b0};
      total++;
      if (observe() !== exp) begin
        bad++; $display("FAIL wrap_up step %0d: got %h want %h", i, observe(), exp);
      end
    end
  endtask

  task automatic test_sat_down();
    logic [12:0] exp;
    set_ctrl(1, 0, 0, 4, 10, 20);
    bus.load = 1; bus.load_val = 8'd13; tick(); bus.load = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = {8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      total++;
      if (observe() !== exp) begin
        bad++; $display("FAIL sat_down step %0d: got %h want %h", i, observe(), exp);
      end
    end
  endtask

  task automatic test_out_of_window();
    logic [12:0] exp;
    set_ctrl(1, 1, 0, 1, 10, 20);
    bus.load = 1; bus.load_val = 8'd200; tick(); bus.load = 0;
    exp = {8'd200, 5'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL load_unclamped: got %h want %h", observe(), exp);
    end
    tick();
    exp = {8'd20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL above_hi: got %h want %h", observe(), exp);
    end
    bus.up_down = 0;
    bus.load = 1; bus.load_val = 8'd5; tick(); bus.load = 0;
    tick();
    exp = {8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL below_lo: got %h want %h", observe(), exp);
    end
  endtask

  task automatic test_lim_err();
    logic [12:0] exp;
    set_ctrl(1, 1, 0, 1, 30, 20);
    tick();
    exp = {8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL lim_err_set: got %h want %h", observe(), exp);
    end
    bus.lo_lim = 8'd10;
    tick();
    exp = {8'd11, 5'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL lim_err_clear: got %h want %h", observe(), exp);
    end
  endtask

  task automatic test_priority();
    logic [12:0] exp;
    rst = 1; bus.load = 1; bus.load_val = 8'd99; bus.en = 1;
    tick(); rst = 0;
    exp = {8'd0, 5'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL rst_over_load: got %h want %h", observe(), exp);
    end
    bus.step = 8'd5; bus.load_val = 8'd77;
    tick(); bus.load = 0;
    exp = {8'd77, 5'b0};
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL load_over_en: got %h want %h", observe(), exp);
    end
    bus.en = 0; tick();
    bus.en = 1; bus.step = 8'd0; tick();
    total++;
    if (observe() !== exp) begin
      bad++; $display("FAIL hold: got %h want %h", observe(), exp);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    int a, b;
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 9) == 0) ? a : $urandom_range(0, 255);
      if ($urandom_range(0, 9) != 0) begin
        if (a > b) begin int t = a; a = b; b = t; end
      end
      set_ctrl($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
               a, b);
      bus.load     = $urandom_range(0, 9) == 0;
      bus.load_val = 8'($urandom);
      rst          = $urandom_range(0, 79) == 0;
      tick();
      rst = 0;
      exp = {8'(m_count), 1'(m_count == int'(bus.lo_lim)), 1'(m_count == int'(bus.hi_lim)),
             m_sat, m_wrap, m_err};
      total++;
      if (observe() !== exp) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h", i, observe(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sat_up_full();
    test_wrap_up();
    test_sat_down();
    test_out_of_window();
    test_lim_err();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/up_down_counter_param.md
# up_down_counter_param

Parametrised up/down counter for control and sequencing paths; the next generation of the team's 4-bit saturating counter. Adds configurable width, programmable lower/upper limits, programmable step, synchronous load, count enable, and a saturate/wrap mode select. Registered event pulses report limit hits for downstream status logic.

## Interface
- WIDTH, 8, counter width in bits (≥2).
- RST_VAL, 0, count value after reset (WIDTH bits).

- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; step applied only when 1.
- up_down  in  1  1 = count up, 0 = count down.
- mode_wrap  in  1  0 = saturate at limit, 1 = wrap to opposite limit.
- step  in  WIDTH  increment/decrement magnitude; 0 = hold.
- lo_lim  in  WIDTH  lower limit, unsigned, inclusive.
- hi_lim  in  WIDTH  upper limit, unsigned, inclusive.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded on load.
- count  out  WIDTH  registered counter value.
- at_lo  out  1  combinational: count == lo_lim.
- at_hi  out  1  combinational: count == hi_lim.
- sat_hit  out  1  registered 1-cycle pulse: step clamped (saturate mode).
- wrap_pulse  out  1  registered 1-cycle pulse: step wrapped (wrap mode).
- lim_err  out  1  registered: lo_lim > hi_lim seen on last clock edge.

## Operation
- Priority per edge: rst > load > (en && step != 0 && window valid) > hold.
- rst: count = RST_VAL; sat_hit, wrap_pulse, lim_err = 0.
- load: count = load_val unmodified (no clamping); sat_hit, wrap_pulse = 0.
- Window valid when lo_lim <= hi_lim. Invalid window: count holds, no pulses, lim_err = 1. lim_err updates every non-reset edge, including load edges.
- Arithmetic in WIDTH+1 bits, unsigned, so no intermediate overflow:
  - Up: nxt = count + step. If nxt > hi_lim: saturate → count = hi_lim, sat_hit = 1; wrap → count = lo_lim, wrap_pulse = 1. Else count = nxt.
  - Down: if step > count or count − step < lo_lim: saturate → count = lo_lim, sat_hit = 1; wrap → count = hi_lim, wrap_pulse = 1. Else count = count − step.
- Wrap lands exactly on the opposite limit; the excess is discarded, not carried modulo.
- Count already at limit:
  - Saturate: a further step in that direction re-asserts sat_hit every enabled cycle, and count stays.
  - Wrap: the step wraps.
- Count outside window (load or limit change):
  - Up step with count > hi_lim, or down step with count < lo_lim: treated as a limit violation (clamp or wrap as above).
  - Up step with count < lo_lim, or down step with count > hi_lim: normal arithmetic.
- en = 0 or step = 0: hold; pulses 0.
- lo_lim == hi_lim: any enabled nonzero step yields count = lo_lim, with a pulse.

## Timing
- Single-cycle latency: inputs sampled at edge N; count and pulses valid after edge N.
- sat_hit / wrap_pulse are high for exactly the cycle following the triggering edge; they are never both high.
- at_lo / at_hi follow count and limits combinationally; there is no extra register stage.
- Reset mid-operation takes effect on the next edge regardless of en, load, or limits. Async rst assertion without a clock edge has no effect.
- Limits, step, and mode may change on any cycle; each edge uses the values sampled at that edge.

## Test plan
- WIDTH=8, RST_VAL=0, lo=0, hi=255, step=1, up, saturate; run 260 enabled cycles from reset -> count reaches 255 at cycle 255; sat_hit pulses on each of cycles 256–260; at_hi=1.
- lo=10, hi=20, step=3, up, wrap, load 18 -> next edges give 10 (wrap_pulse=1), then 13, 16, 19, then 10 (wrap_pulse=1).
- lo=10, hi=20, step=4, down, saturate, load 13 -> next edge gives 10 with sat_hit=1; next edge stays 10 with sat_hit=1; at_lo=1.
- Load 200 with hi=20, up, step=1, saturate -> next edge gives 20 with sat_hit=1. Load 5 with lo=10, down -> next edge gives 10 with sat_hit=1.
- Set lo=30, hi=20, en=1 -> count holds and lim_err=1. Restore lo=10 -> lim_err=0 after the next edge, and counting resumes.
- Assert rst together with load=1 and en=1 mid-count -> count = RST_VAL and all pulses 0 on that edge. Assert load with en=1 -> load_val wins.
